// File: rtl/alu_defs.sv
// Shared ALU operation codes, MIPS opcode/funct constants and FSM encoding
// used by the issue engine, its decoder and the datapath ALU.
package alu_defs;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_NOR     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_SLL     = 4'b0110;
  localparam logic [3:0] ALU_LUI     = 4'b0111;
  localparam logic [3:0] ALU_DEFAULT = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_RT   = 2'd0,
    SEL_SEXT = 2'd1,
    SEL_ZEXT = 2'd2
  } imm_sel_t;

  typedef enum logic {
    DEST_RT = 1'b0,
    DEST_RD = 1'b1
  } dest_sel_t;

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU driven by the issue engine; shares the
// operation encoding from alu_defs.
module alu
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [4:0]            shamt,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SRL: result = b >> shamt;
      ALU_SLL: result = b << shamt;
      ALU_LUI: result = b << 16;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_op_decoder.sv
// Combinational MIPS opcode/funct decoder producing the ALU operation and
// the writeback/branch controls for one instruction.
module alu_op_decoder
  import alu_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output imm_sel_t   imm_sel,
  output dest_sel_t  dest_sel,
  output logic       wr_en,
  output logic       is_beq,
  output logic       is_bne,
  output logic       illegal
);

  always_comb begin
    alu_op   = ALU_DEFAULT;
    imm_sel  = SEL_RT;
    dest_sel = DEST_RT;
    wr_en    = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dest_sel = DEST_RD;
        wr_en    = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          default: begin
            wr_en   = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        alu_op  = ALU_ADD;
        imm_sel = SEL_SEXT;
        wr_en   = 1'b1;
      end
      OP_ANDI: begin
        alu_op  = ALU_AND;
        imm_sel = SEL_ZEXT;
        wr_en   = 1'b1;
      end
      OP_ORI: begin
        alu_op  = ALU_OR;
        imm_sel = SEL_ZEXT;
        wr_en   = 1'b1;
      end
      OP_LUI: begin
        alu_op  = ALU_LUI;
        imm_sel = SEL_ZEXT;
        wr_en   = 1'b1;
      end
      // Loads/stores only need the address; the memory stage owns the transfer.
      OP_LW, OP_SW: begin
        alu_op  = ALU_ADD;
        imm_sel = SEL_SEXT;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_BNE: begin
        alu_op = ALU_SUB;
        is_bne = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue engine: captures an instruction, drives the ALU, samples
// its result and presents a held writeback/branch response.
module alu_issue_ctrl
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [4:0]            alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_wr_en,
  output logic [REG_AW-1:0]     res_wr_addr,
  output logic                  branch_taken,
  output logic                  illegal
);

  state_t                state;
  logic [5:0]            op_q;
  logic [20:0]           low_q;
  logic [DATA_WIDTH-1:0] rs_q;
  logic [DATA_WIDTH-1:0] rt_q;

  logic [3:0]            dec_alu_op;
  imm_sel_t              dec_imm_sel;
  dest_sel_t             dec_dest_sel;
  logic                  dec_wr_en;
  logic                  dec_is_beq;
  logic                  dec_is_bne;
  logic                  dec_illegal;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [4:0]            shamt_sel;
  logic [REG_AW-1:0]     dest_addr;

  // The rs field is not needed here: its value arrives already read on rs_data.
  logic unused_rs_field;
  assign unused_rs_field = ^instr[25:21];

  alu_op_decoder u_dec (
    .opcode   (op_q),
    .funct    (low_q[5:0]),
    .alu_op   (dec_alu_op),
    .imm_sel  (dec_imm_sel),
    .dest_sel (dec_dest_sel),
    .wr_en    (dec_wr_en),
    .is_beq   (dec_is_beq),
    .is_bne   (dec_is_bne),
    .illegal  (dec_illegal)
  );

  always_comb begin
    operand_b = rt_q;
    case (dec_imm_sel)
      SEL_SEXT: operand_b = {{(DATA_WIDTH-16){low_q[15]}}, low_q[15:0]};
      SEL_ZEXT: operand_b = {{(DATA_WIDTH-16){1'b0}}, low_q[15:0]};
      default:  operand_b = rt_q;
    endcase
  end

  assign shamt_sel = (dec_alu_op == ALU_SLL || dec_alu_op == ALU_SRL) ? low_q[10:6] : 5'd0;
  assign dest_addr = (dec_dest_sel == DEST_RD) ? low_q[15:11] : low_q[20:16];

  // IDLE capture stage: instruction and operands, data-only registers
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && instr_valid) begin
      op_q  <= instr[31:26];
      low_q <= instr[20:0];
      rs_q  <= rs_data;
      rt_q  <= rt_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      instr_ready  <= 1'b1;
      res_valid    <= 1'b0;
      res_wr_en    <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      alu_op       <= ALU_DEFAULT;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_shamt    <= '0;
      res_data     <= '0;
      res_wr_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_ready <= 1'b0;
            state       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_op       <= dec_alu_op;
          alu_a        <= rs_q;
          alu_b        <= operand_b;
          alu_shamt    <= shamt_sel;
          res_wr_addr  <= dest_addr;
          res_wr_en    <= dec_wr_en;
          illegal      <= dec_illegal;
          branch_taken <= 1'b0;
          if (dec_illegal) begin
            res_data  <= '0;
            res_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            state <= ST_EXEC;
          end
        end
        // Decoder output stays valid here because the capture registers only load in IDLE.
        ST_EXEC: begin
          res_data     <= alu_result;
          branch_taken <= (dec_is_beq & alu_zero) | (dec_is_bne & ~alu_zero);
          res_valid    <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl with the real ALU: directed cases, stalls, reset
// abort and randomized instructions checked against a behavioural model.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_wr_en;
  logic [4:0]  res_wr_addr;
  logic        branch_taken;
  logic        illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_WIDTH(32), .REG_AW(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .alu_op       (alu_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_shamt    (alu_shamt),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_wr_en    (res_wr_en),
    .res_wr_addr  (res_wr_addr),
    .branch_taken (branch_taken),
    .illegal      (illegal)
  );

  alu #(.DATA_WIDTH(32)) u_alu (
    .alu_op (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .shamt  (alu_shamt),
    .result (alu_result),
    .zero   (alu_zero)
  );

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [4:0]  addr;
    logic        br;
    logic        ill;
    logic [4:0]  sh;
  } exp_t;

  // Architectural meaning of each instruction, computed directly from MIPS semantics.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [4:0]  sh;
    op   = ins[31:26];
    fn   = ins[5:0];
    imm  = ins[15:0];
    sh   = ins[10:6];
    simm = {{16{imm[15]}}, imm};
    zimm = {16'h0000, imm};
    e.data = 32'h0; e.we = 1'b0; e.addr = ins[20:16]; e.br = 1'b0; e.ill = 1'b0; e.sh = 5'd0;
    if (op == 6'h00) begin
      e.addr = ins[15:11];
      e.we   = 1'b1;
      if (fn == 6'h20 || fn == 6'h21)      e.data = rs + rt;
      else if (fn == 6'h22 || fn == 6'h23) e.data = rs - rt;
      else if (fn == 6'h24)                e.data = rs & rt;
      else if (fn == 6'h25)                e.data = rs | rt;
      else if (fn == 6'h27)                e.data = ~(rs | rt);
      else if (fn == 6'h00) begin e.data = rt << sh; e.sh = sh; end
      else if (fn == 6'h02) begin e.data = rt >> sh; e.sh = sh; end
      else begin e.ill = 1'b1; e.we = 1'b0; end
    end else if (op == 6'h08 || op == 6'h09) begin e.data = rs + simm; e.we = 1'b1; end
    else if (op == 6'h0C) begin e.data = rs & zimm; e.we = 1'b1; end
    else if (op == 6'h0D) begin e.data = rs | zimm; e.we = 1'b1; end
    else if (op == 6'h0F) begin e.data = {imm, 16'h0000}; e.we = 1'b1; end
    else if (op == 6'h23 || op == 6'h2B) e.data = rs + simm;
    else if (op == 6'h04) begin e.data = rs - rt; e.br = (rs == rt); end
    else if (op == 6'h05) begin e.data = rs - rt; e.br = (rs != rt); end
    else e.ill = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input exp_t e);
    chk("res_valid", {31'b0, res_valid}, 32'd1);
    chk("res_data", res_data, e.data);
    chk("res_wr_en", {31'b0, res_wr_en}, {31'b0, e.we});
    chk("branch_taken", {31'b0, branch_taken}, {31'b0, e.br});
    chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
    chk("alu_shamt", {27'b0, alu_shamt}, {27'b0, e.sh});
    chk("instr_ready_busy", {31'b0, instr_ready}, 32'd0);
    if (!e.ill) chk("res_wr_addr", {27'b0, res_wr_addr}, {27'b0, e.addr});
  endtask

  // Issue one instruction, hold res_ready low for 'stall' cycles, then handshake.
  task automatic run(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt, input int stall);
    exp_t e;
    int   n;
    e = model(ins, rs, rt);
    @(negedge clk);
    instr = ins; rs_data = rs; rt_data = rt; instr_valid = 1'b1; res_ready = 1'b0;
    chk("instr_ready_idle", {31'b0, instr_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; instr = $urandom; rs_data = $urandom; rt_data = $urandom;
    chk("instr_ready_after_accept", {31'b0, instr_ready}, 32'd0);
    n = 1;
    while (res_valid !== 1'b1 && n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency_edges", n, e.ill ? 32'd2 : 32'd3);
    chk_resp(e);
    for (int k = 0; k < stall; k++) begin
      instr_valid = 1'b1;
      @(negedge clk);
      chk_resp(e);
    end
    instr_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_after_hs", {31'b0, res_valid}, 32'd0);
    chk("instr_ready_after_hs", {31'b0, instr_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_wr_en", {31'b0, res_wr_en}, 32'd0);
    chk("rst_branch", {31'b0, branch_taken}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'hF);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_alu_shamt", {27'b0, alu_shamt}, 32'd0);
    chk("rst_wr_addr", {27'b0, res_wr_addr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] fns [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h00, 6'h02};
    logic [5:0] ops [9] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [31:0] ins;
    logic [31:0] rs;
    logic [31:0] rt;

    reset = 1'b0; instr_valid = 1'b0; res_ready = 1'b0;
    instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    reset = 1'b1;
    @(negedge clk);

    run(32'h00221820, 32'd5, 32'd7, 0);
    run(32'h000220C0, 32'd0, 32'd1, 0);
    run(32'h3C051234, 32'd0, 32'd0, 0);
    run(32'h2001FFFF, 32'd0, 32'd0, 0);
    run(32'h10220004, 32'd9, 32'd9, 0);
    run(32'h14220004, 32'd9, 32'd9, 0);
    run(32'h00221820, 32'hFFFFFFFF, 32'd2, 5);
    run(32'hFC000000, 32'h1234, 32'h5678, 2);

    // Abort an sll while it sits in EXEC.
    @(negedge clk);
    instr = 32'h000220C0; rs_data = 32'd0; rt_data = 32'd1; instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("shamt_in_exec", {27'b0, alu_shamt}, 32'd3);
    reset = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_resp_after_abort", {31'b0, res_valid}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ins = $urandom;
      rs  = $urandom;
      rt  = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ins[31:26] = 6'h00;
        9:          ins[31:26] = 6'h3F;
        default:    ins[31:26] = ops[$urandom_range(0, 8)];
      endcase
      if (ins[31:26] == 6'h00)
        ins[5:0] = ($urandom_range(0, 7) == 0) ? 6'h3F : fns[$urandom_range(0, 8)];
      if ($urandom_range(0, 2) == 0) rt = rs;
      run(ins, rs, rt, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
